vec_ldst_seq: RTL and testbench
===============================

# vec_ldst_seq

Vector load/store sequencer for the CVP14 vector core. On a `vld` or `vst` command from the core's decode logic, it moves one 16-element × 16-bit vector between external memory and the vector register file's serial port, one element per cycle. It owns the memory address, strobe and data lines while active, and drives the vector register file serial write/read port.

## Interface

Parameters:
- `ELEMS`, 16, elements per vector; the element counter is 4 bits for the default.
- `DW`, 16, element and memory data width.
- `AW`, 16, memory address width.

Ports:
- `Clk1`  in  1  sole clock; all state is updated on its rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state.
- `Start`  in  1  command strobe; sampled only in IDLE.
- `Op`  in  1  command: 0 = vld (memory → register), 1 = vst (register → memory).
- `BaseAddr`  in  AW  first memory address; captured when `Start` is accepted.
- `VRegSel`  in  3  vector register number; captured when `Start` is accepted.
- `Busy`  out  1  high from the cycle after `Start` is accepted until the cycle after the last transfer.
- `Done`  out  1  one-cycle completion pulse.
- `MemAddr`  out  AW  memory address.
- `MemRD`  out  1  memory read strobe.
- `MemWR`  out  1  memory write strobe.
- `MemDataOut`  out  DW  write data to memory.
- `MemDataIn`  in  DW  read data from memory; valid one cycle after `MemRD`.
- `VAddr`  out  3  vector register number (the captured `VRegSel`).
- `VElem`  out  4  element index for the serial port.
- `VWR_s`  out  1  vector serial write strobe.
- `VRD_s`  out  1  vector serial read strobe.
- `VDataOut_s`  out  DW  element written to the vector register.
- `VDataIn_s`  in  DW  element read from the vector register; valid one cycle after `VRD_s`.

## Operation

- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE
  - `Start`=1 captures `Op`, `BaseAddr` and `VRegSel`, sets issue index i=0, and moves to ISSUE.
  - `Start`=0 stays in IDLE.
- ISSUE, vld, each cycle:
  - Drives `MemRD`=1 and `MemAddr`=Base+i.
  - In the same cycle, writes the previous element: when i>0, `VWR_s`=1, `VElem`=i−1, `VDataOut_s`=`MemDataIn`.
- ISSUE, vst, each cycle:
  - Drives `VRD_s`=1 and `VElem`=i.
  - When i>0, also writes the previous element: `MemWR`=1, `MemAddr`=Base+i−1, `MemDataOut`=`VDataIn_s`.
- ISSUE exit: after i=ELEMS−1 is issued, moves to DRAIN.
- DRAIN: completes the final element (index ELEMS−1) with the same write rules as ISSUE, then moves to DONE.
- DONE: `Done`=1 for one cycle, then returns to IDLE.
- Address arithmetic is modulo 2^AW. Base=0xFFFF wraps: element 1 goes to 0x0000.
- `VAddr` holds the captured register number for the whole command.
- `Start` while `Busy` is ignored; no queueing.
- At most one of `MemRD`/`MemWR` is high in any cycle, and at most one of `VWR_s`/`VRD_s`.
- No strobe is ever asserted in IDLE or DONE.

## Timing

- Reset values: all outputs are 0 and the state is IDLE.
- `Reset` asserted mid-command:
  - All strobes drop immediately (asynchronously).
  - The partial transfer is abandoned and `Done` is not pulsed.
  - Already-written elements stay written.
- Latency: `Start` is accepted in cycle 0.
  - ISSUE spans cycles 1..16.
  - DRAIN is cycle 17.
  - `Done` is high in cycle 18.
  - `Busy` is high in cycles 1..17; `Busy`=0 in cycle 18.
- Throughput: one element per cycle. A new `Start` is accepted at the earliest in cycle 19, in IDLE.
- Memory and register file are assumed to have fixed 1-cycle read latency. There is no wait-state input.
- A `Start` held high continuously re-launches a command one cycle after each `Done`.

## Configuration

- `VLS_STRIDE_EN` defined:
  - Adds input `Stride` (AW bits), captured at `Start`.
  - Element k address is Base + k·Stride, accumulated by addition modulo 2^AW.
  - Stride=0 is legal: all elements use the same address.
- `VLS_STRIDE_EN` undefined:
  - The `Stride` port is absent.
  - Stride is fixed at 1 (unit-stride, as described in Operation).

## Test plan

- vld, Base=0x0100, VRegSel=3, memory[0x0100+k]=0xA000+k → `VWR_s` in cycles 2..17 with `VElem`=0..15, data 0xA000..0xA00F, `VAddr`=3, `Done` in cycle 18.
- vst, Base=0x2000, vector reg 5 element k=0x5500+k → `MemWR` in cycles 2..17, address 0x2000..0x200F, data 0x5500..0x550F; `MemRD` is never asserted.
- vld with Base=0xFFF8 → addresses 0xFFF8..0xFFFF, then 0x0000..0x0007; all 16 elements are written correctly.
- `Start` pulsed during cycles 5 and 17 of an active command → ignored; exactly one `Done`; the next `Start` in cycle 19 is accepted.
- `Reset` asserted in cycle 9 of vst → all outputs are 0 immediately; no `Done`; memory holds only elements 0..6; a fresh vld after reset completes normally.
- With `VLS_STRIDE_EN`, vst, Base=0x0010, Stride=4 → write addresses 0x0010, 0x0014, …, 0x004C.

Source files
------------

// File: rtl/vec_ldst_seq.sv
// rtl/vec_ldst_seq.sv - vector load/store sequencer moving one vector element per cycle between memory and the VRF serial port
// Optional feature macro: VLS_STRIDE_EN (adds Stride input for strided addressing).
module vec_ldst_seq #(
    parameter int ELEMS = 16,
    parameter int DW    = 16,
    parameter int AW    = 16
) (
    input  logic                          Clk1,
    input  logic                          Reset,
    input  logic                          Start,
    input  logic                          Op,
    input  logic [AW-1:0]                 BaseAddr,
    input  logic [2:0]                    VRegSel,
`ifdef VLS_STRIDE_EN
    input  logic [AW-1:0]                 Stride,
`endif
    output logic                          Busy,
    output logic                          Done,
    output logic [AW-1:0]                 MemAddr,
    output logic                          MemRD,
    output logic                          MemWR,
    output logic [DW-1:0]                 MemDataOut,
    input  logic [DW-1:0]                 MemDataIn,
    output logic [2:0]                    VAddr,
    output logic [$clog2(ELEMS)-1:0]      VElem,
    output logic                          VWR_s,
    output logic                          VRD_s,
    output logic [DW-1:0]                 VDataOut_s,
    input  logic [DW-1:0]                 VDataIn_s
);

    localparam int IW = $clog2(ELEMS);
    localparam logic [IW-1:0] LAST = IW'(ELEMS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic          op;
    logic [AW-1:0] addr;
    logic [AW-1:0] prev_addr;
    logic [2:0]    vreg;
    logic [IW-1:0] idx;
    logic [AW-1:0] stride;

`ifndef VLS_STRIDE_EN
    assign stride = AW'(1);
`endif

    // addr tracks the element being issued; prev_addr trails it by one for the write-back half
    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            op        <= 1'b0;
            addr      <= '0;
            prev_addr <= '0;
            vreg      <= '0;
            idx       <= '0;
`ifdef VLS_STRIDE_EN
            stride    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        op     <= Op;
                        addr   <= BaseAddr;
                        vreg   <= VRegSel;
                        idx    <= '0;
`ifdef VLS_STRIDE_EN
                        stride <= Stride;
`endif
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    prev_addr <= addr;
                    addr      <= addr + stride;
                    if (idx == LAST) begin
                        state <= S_DRAIN;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_DRAIN: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    logic          issuing;
    logic          has_prev;
    logic [IW-1:0] wr_elem;

    // Strobes and data are decoded from state so a reset removes them immediately
    always_comb begin
        issuing    = (state == S_ISSUE);
        has_prev   = (issuing && idx != '0) || (state == S_DRAIN);
        wr_elem    = (state == S_DRAIN) ? idx : idx - IW'(1);
        Busy       = issuing || (state == S_DRAIN);
        Done       = (state == S_DONE);
        VAddr      = vreg;
        MemRD      = issuing && !op;
        VRD_s      = issuing && op;
        VWR_s      = has_prev && !op;
        MemWR      = has_prev && op;
        MemAddr    = '0;
        MemDataOut = '0;
        VElem      = '0;
        VDataOut_s = '0;
        if (MemRD) begin
            MemAddr = addr;
        end else if (MemWR) begin
            MemAddr    = prev_addr;
            MemDataOut = VDataIn_s;
        end
        if (VWR_s) begin
            VElem      = wr_elem;
            VDataOut_s = MemDataIn;
        end else if (VRD_s) begin
            VElem = idx;
        end
    end

endmodule

// File: tb/tb_vec_ldst_seq.sv
// tb/tb_vec_ldst_seq.sv - scoreboard bench for vec_ldst_seq with memory and VRF response models
module tb_vec_ldst_seq;

    logic        Clk1 = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Op = 1'b0;
    logic [15:0] BaseAddr = '0;
    logic [2:0]  VRegSel = '0;
    logic [15:0] Stride = 16'd1;
    logic        Busy, Done, MemRD, MemWR, VWR_s, VRD_s;
    logic [15:0] MemAddr, MemDataOut, VDataOut_s;
    logic [15:0] MemDataIn = '0;
    logic [15:0] VDataIn_s = '0;
    logic [2:0]  VAddr;
    logic [3:0]  VElem;

    vec_ldst_seq dut (
        .Clk1(Clk1), .Reset(Reset), .Start(Start), .Op(Op), .BaseAddr(BaseAddr), .VRegSel(VRegSel),
`ifdef VLS_STRIDE_EN
        .Stride(Stride),
`endif
        .Busy(Busy), .Done(Done), .MemAddr(MemAddr), .MemRD(MemRD), .MemWR(MemWR),
        .MemDataOut(MemDataOut), .MemDataIn(MemDataIn), .VAddr(VAddr), .VElem(VElem),
        .VWR_s(VWR_s), .VRD_s(VRD_s), .VDataOut_s(VDataOut_s), .VDataIn_s(VDataIn_s)
    );

    always #5 Clk1 = ~Clk1;

    // memory returns mpat_val + (addr - mpat_addr); VRF returns vpat + element
    logic [15:0] mpat_addr = '0, mpat_val = '0, vpat = '0;
    always @(posedge Clk1) begin
        MemDataIn <= MemRD ? mpat_val + (MemAddr - mpat_addr) : 16'hDEAD;
        VDataIn_s <= VRD_s ? vpat + {12'd0, VElem} : 16'hBEEF;
    end

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] loc;
        logic [2:0]  vreg;
        logic [15:0] data;
    } ev_t;

    ev_t wr_q[$];
    ev_t rd_q[$];
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int rd_cnt = 0;

    function automatic ev_t mk(input logic [1:0] k, input logic [15:0] l, input logic [2:0] v, input logic [15:0] d);
        ev_t e;
        e.kind = k; e.loc = l; e.vreg = v; e.data = d;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pop_chk(input bit is_wr, input ev_t got);
        ev_t e;
        total++;
        if ((is_wr && wr_q.size() == 0) || (!is_wr && rd_q.size() == 0)) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d loc=%h vreg=%0d data=%h expected none",
                     got.kind, got.loc, got.vreg, got.data);
            return;
        end
        if (is_wr) e = wr_q.pop_front();
        else       e = rd_q.pop_front();
        if (got !== e) begin
            bad++;
            $display("FAIL event: got kind=%0d loc=%h vreg=%0d data=%h expected kind=%0d loc=%h vreg=%0d data=%h",
                     got.kind, got.loc, got.vreg, got.data, e.kind, e.loc, e.vreg, e.data);
        end
    endtask

    always @(negedge Clk1) begin
        if (MemRD || MemWR || VWR_s || VRD_s)
            chk("strobe_exclusive", {62'd0, MemRD & MemWR, VWR_s & VRD_s}, 64'd0);
        if (VWR_s) pop_chk(1'b1, mk(2'd0, {12'd0, VElem}, VAddr, VDataOut_s));
        if (MemWR) pop_chk(1'b1, mk(2'd1, MemAddr, 3'd0, MemDataOut));
        if (MemRD) pop_chk(1'b0, mk(2'd2, MemAddr, 3'd0, 16'd0));
        if (VRD_s) pop_chk(1'b0, mk(2'd3, {12'd0, VElem}, VAddr, 16'd0));
        if (Done)  done_cnt++;
        if (MemRD) rd_cnt++;
    end

    task automatic push_cmd(input bit op, input logic [15:0] base, input logic [2:0] vreg, input logic [15:0] stride,
                            input int nrd, input int nwr, input logic [15:0] pat);
        logic [15:0] a;
        for (int k = 0; k < nrd; k++) begin
            a = base + 16'(k) * stride;
            if (!op) rd_q.push_back(mk(2'd2, a, 3'd0, 16'd0));
            else     rd_q.push_back(mk(2'd3, 16'(k), vreg, 16'd0));
        end
        for (int k = 0; k < nwr; k++) begin
            a = base + 16'(k) * stride;
            if (!op) wr_q.push_back(mk(2'd0, 16'(k), vreg, pat + 16'(k)));
            else     wr_q.push_back(mk(2'd1, a, 3'd0, pat + 16'(k)));
        end
    endtask

    task automatic run_cmd(input bit op, input logic [15:0] base, input logic [2:0] vreg, input logic [15:0] stride,
                           input logic [15:0] pat, input bit stray, input string nm);
        int d0, b, dc;
        if (!op) begin mpat_addr = base; mpat_val = pat; end
        else vpat = pat;
        push_cmd(op, base, vreg, stride, 16, 16, pat);
        d0 = done_cnt; b = 0; dc = -1;
        @(posedge Clk1); #1;
        Start = 1'b1; Op = op; BaseAddr = base; VRegSel = vreg; Stride = stride;
        for (int c = 1; c <= 25; c++) begin
            @(posedge Clk1); #1;
            if (c == 1) Start = 1'b0;
            if (c == 2) begin BaseAddr = 16'h7777; VRegSel = 3'd0; Op = ~op; end
            if (stray && (c == 5 || c == 17)) Start = 1'b1;
            if (stray && (c == 6 || c == 18)) Start = 1'b0;
            if (Busy) b++;
            if (Done) begin dc = c; break; end
        end
        chk({nm, "_done_cycle"}, 64'(dc), 64'd18);
        chk({nm, "_busy_cycles"}, 64'(b), 64'd17);
        @(negedge Clk1); #1;
        chk({nm, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        chk({nm, "_queue_left"}, 64'(wr_q.size() + rd_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, d0;
        repeat (2) @(posedge Clk1);
        #1;
        chk("reset_outputs", {Busy, Done, MemRD, MemWR, VWR_s, VRD_s, VAddr, VElem, MemAddr, MemDataOut, VDataOut_s},
            64'd0);
        Reset = 1'b0;

        run_cmd(1'b0, 16'h0100, 3'd3, 16'd1, 16'hA000, 1'b0, "vld_basic");
        r0 = rd_cnt;
        run_cmd(1'b1, 16'h2000, 3'd5, 16'd1, 16'h5500, 1'b0, "vst_basic");
        chk("vst_no_memrd", 64'(rd_cnt - r0), 64'd0);
        run_cmd(1'b0, 16'hFFF8, 3'd1, 16'd1, 16'hB000, 1'b1, "vld_wrap_stray");
        run_cmd(1'b1, 16'h0040, 3'd2, 16'd1, 16'h1200, 1'b0, "vst_back_to_back");

        // reset in cycle 9 of a vst: only elements 0..6 reach memory
        vpat = 16'h7700;
        push_cmd(1'b1, 16'h3000, 3'd4, 16'd1, 8, 7, 16'h7700);
        d0 = done_cnt;
        @(posedge Clk1); #1;
        Start = 1'b1; Op = 1'b1; BaseAddr = 16'h3000; VRegSel = 3'd4; Stride = 16'd1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge Clk1); #1;
            if (c == 1) Start = 1'b0;
        end
        Reset = 1'b1;
        #1;
        chk("rst_mid_outputs", {Busy, Done, MemRD, MemWR, VWR_s, VRD_s, VAddr, VElem, MemAddr, MemDataOut, VDataOut_s},
            64'd0);
        repeat (3) @(posedge Clk1);
        #1;
        Reset = 1'b0;
        @(negedge Clk1); #1;
        chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
        chk("rst_mid_queue_left", 64'(wr_q.size() + rd_q.size()), 64'd0);

        run_cmd(1'b0, 16'h0800, 3'd7, 16'd1, 16'hC000, 1'b0, "vld_after_reset");
`ifdef VLS_STRIDE_EN
        run_cmd(1'b1, 16'h0010, 3'd6, 16'd4, 16'h3300, 1'b0, "vst_stride4");
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
